// File: rtl/trv_issue_ctrl.sv
// trv_issue_ctrl: decode-to-execute issue gate with register scoreboard,
// in-flight window, branch hold and stall counter. Option: TRV_ISSUE_BYPASS_EN.
module trv_issue_ctrl #(
   parameter int MAX_INFLIGHT = 4,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dec_valid,
   output logic                   dec_ready,
   input  logic [4:0]             dec_rs1,
   input  logic [4:0]             dec_rs2,
   input  logic [4:0]             dec_rd,
   input  logic                   dec_use_rs1,
   input  logic                   dec_use_rs2,
   input  logic                   dec_is_br,
   output logic                   iss_valid,
   input  logic                   iss_ready,
   input  logic                   wb_valid,
   input  logic [4:0]             wb_rd,
   input  logic                   br_valid,
   input  logic                   br_taken,
   output logic                   flush,
   output logic                   busy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);

   state_t                 r_state;
   logic                   r_flush;
   logic [31:0]            r_sb;
   logic [3:0]             r_inflight;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic        w_wb_hit;
   logic        w_wb_dec;
   logic [31:0] w_wb_mask;
   logic [31:0] w_set_mask;
   logic [31:0] w_sb_chk;
   logic [3:0]  w_inf_chk;
   logic        w_hazard;
   logic        w_full;
   logic        w_fire;

   assign w_wb_hit  = wb_valid && (wb_rd != 5'd0);
   assign w_wb_mask = w_wb_hit ? (32'd1 << wb_rd) : 32'd0;
   // A writeback with nothing in flight is spurious and must not underflow.
   assign w_wb_dec  = wb_valid && (r_inflight != 4'd0);

`ifdef TRV_ISSUE_BYPASS_EN
   assign w_sb_chk  = r_sb & ~w_wb_mask;
   assign w_inf_chk = r_inflight - {3'd0, w_wb_dec};
`else
   assign w_sb_chk  = r_sb;
   assign w_inf_chk = r_inflight;
`endif

   assign w_hazard = (dec_use_rs1 && (dec_rs1 != 5'd0) && w_sb_chk[dec_rs1])
                  || (dec_use_rs2 && (dec_rs2 != 5'd0) && w_sb_chk[dec_rs2])
                  || ((dec_rd != 5'd0) && w_sb_chk[dec_rd]);
   assign w_full   = (w_inf_chk == LP_MAX);

   assign iss_valid = (r_state == RUN) && dec_valid && !w_hazard && !w_full;
   assign dec_ready = iss_valid && iss_ready;
   assign w_fire    = dec_valid && dec_ready;

   assign w_set_mask = (w_fire && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;

   assign flush     = r_flush;
   assign busy      = (r_inflight != 4'd0) || (r_state != RUN);
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_flush     <= 1'b0;
         r_sb        <= 32'd0;
         r_inflight  <= 4'd0;
         r_stall_cnt <= '0;
      end else begin
         // Clear first, then set, so a same-index set wins.
         r_sb <= (r_sb & ~w_wb_mask) | w_set_mask;

         case ({w_fire, w_wb_dec})
            2'b10:   r_inflight <= r_inflight + 4'd1;
            2'b01:   r_inflight <= r_inflight - 4'd1;
            default: r_inflight <= r_inflight;
         endcase

         if (dec_valid && !dec_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;

         r_flush <= 1'b0;
         unique case (r_state)
            RUN: begin
               if (w_fire && dec_is_br)
                  r_state <= BR_WAIT;
            end
            BR_WAIT: begin
               if (br_valid) begin
                  r_state <= br_taken ? FLUSH : RUN;
                  r_flush <= br_taken;
               end
            end
            FLUSH: begin
               r_state <= RUN;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trv_issue_ctrl.sv
// Directed bench for trv_issue_ctrl: window, RAW/WAW, branch hold,
// scoreboard set/clear collision, saturation and async reset.
module tb_trv_issue_ctrl;
   localparam int SW = 5;
`ifdef TRV_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_valid, dec_ready;
   logic [4:0]    dec_rs1, dec_rs2, dec_rd;
   logic          dec_use_rs1, dec_use_rs2, dec_is_br;
   logic          iss_valid, iss_ready;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic          br_valid, br_taken;
   logic          flush, busy;
   logic [SW-1:0] stall_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   trv_issue_ctrl #(.MAX_INFLIGHT(4), .STALL_CNT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_is_br(dec_is_br),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .br_valid(br_valid), .br_taken(br_taken),
      .flush(flush), .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
      dec_use_rs1 = 0; dec_use_rs2 = 0; dec_is_br = 0;
      iss_ready = 1; wb_valid = 0; wb_rd = 0;
      br_valid = 0; br_taken = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   task automatic op(input logic [4:0] rd, input logic [4:0] rs1,
                     input logic use1, input logic br);
      dec_valid = 1; dec_rd = rd; dec_rs1 = rs1;
      dec_use_rs1 = use1; dec_is_br = br;
   endtask

   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      chk("rst_iss_valid", {31'd0, iss_valid}, 0);
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_stall", {27'd0, stall_cnt}, 0);
      cyc();
      rst = 0;

      // Window fill: rd 1..4 back to back, fifth op waits for a writeback
      for (int i = 1; i <= 4; i++) begin
         op(5'(i), 0, 0, 0);
         @(negedge clk);
         chk("fill_ready", {31'd0, dec_ready}, 1);
         cyc();
      end
      chk("fill_inflight", {28'd0, dut.r_inflight}, 4);
      chk("fill_busy", {31'd0, busy}, 1);
      op(5, 0, 0, 0);
      @(negedge clk);
      chk("full_stall", {31'd0, dec_ready}, 0);
      cyc();
      wb_valid = 1; wb_rd = 1;
      @(negedge clk);
      chk("full_wb_cycle", {31'd0, dec_ready}, {31'd0, BYP});
      cyc();
      wb_valid = 0;
      if (!BYP) begin
         @(negedge clk);
         chk("full_after_wb", {31'd0, dec_ready}, 1);
         cyc();
      end
      idle();
      chk("full_stall_cnt", {27'd0, stall_cnt}, BYP ? 1 : 2);
      chk("full_inflight2", {28'd0, dut.r_inflight}, 4);
      for (int i = 2; i <= 5; i++) begin
         wb_valid = 1; wb_rd = 5'(i);
         cyc();
      end
      idle();
      chk("drain_inflight", {28'd0, dut.r_inflight}, 0);
      chk("drain_sb", dut.r_sb, 0);
      @(negedge clk);
      chk("drain_busy", {31'd0, busy}, 0);

      // RAW on x5
      do_reset();
      op(5, 0, 0, 0);
      cyc();
      op(6, 5, 1, 0);
      @(negedge clk);
      chk("raw_stall1", {31'd0, dec_ready}, 0);
      cyc();
      @(negedge clk);
      chk("raw_stall2", {31'd0, dec_ready}, 0);
      cyc();
      wb_valid = 1; wb_rd = 5;
      @(negedge clk);
      chk("raw_wb_cycle", {31'd0, dec_ready}, {31'd0, BYP});
      cyc();
      wb_valid = 0;
      if (!BYP) begin
         @(negedge clk);
         chk("raw_after_wb", {31'd0, dec_ready}, 1);
         cyc();
      end
      idle();
      chk("raw_stall_cnt", {27'd0, stall_cnt}, BYP ? 2 : 3);
      chk("raw_sb", dut.r_sb, 32'h40);
      chk("raw_inflight", {28'd0, dut.r_inflight}, 1);

      // WAW: rd 6 busy blocks a second writer of x6
      op(6, 0, 0, 0);
      @(negedge clk);
      chk("waw_stall", {31'd0, dec_ready}, 0);
      cyc();

      // Taken branch
      do_reset();
      op(0, 0, 0, 1);
      @(negedge clk);
      chk("br_fire", {31'd0, dec_ready}, 1);
      cyc();
      op(0, 0, 0, 0);
      @(negedge clk);
      chk("brw_ready1", {31'd0, dec_ready}, 0);
      chk("brw_busy", {31'd0, busy}, 1);
      cyc();
      @(negedge clk);
      chk("brw_ready2", {31'd0, dec_ready}, 0);
      cyc();
      br_valid = 1; br_taken = 1;
      @(negedge clk);
      chk("brt_res_ready", {31'd0, dec_ready}, 0);
      chk("brt_res_flush", {31'd0, flush}, 0);
      cyc();
      br_valid = 0; br_taken = 0;
      @(negedge clk);
      chk("brt_flush", {31'd0, flush}, 1);
      chk("brt_fl_ready", {31'd0, dec_ready}, 0);
      cyc();
      @(negedge clk);
      chk("brt_run_flush", {31'd0, flush}, 0);
      chk("brt_run_ready", {31'd0, dec_ready}, 1);
      dec_valid = 0;
      cyc();

      // Not-taken branch, and stray br_valid in RUN
      do_reset();
      op(0, 0, 0, 1);
      cyc();
      op(0, 0, 0, 0);
      br_valid = 1; br_taken = 0;
      @(negedge clk);
      chk("brn_res_ready", {31'd0, dec_ready}, 0);
      cyc();
      br_valid = 0;
      @(negedge clk);
      chk("brn_flush", {31'd0, flush}, 0);
      chk("brn_ready", {31'd0, dec_ready}, 1);
      dec_valid = 0;
      br_valid = 1; br_taken = 1;
      cyc();
      br_valid = 0; br_taken = 0;
      @(negedge clk);
      chk("stray_br_flush", {31'd0, flush}, 0);
      cyc();

      // Same-cycle set and clear of x7
      do_reset();
      op(3, 0, 0, 0);
      cyc();
      op(7, 0, 0, 0);
      wb_valid = 1; wb_rd = 7;
      @(negedge clk);
      chk("col_ready", {31'd0, dec_ready}, 1);
      cyc();
      idle();
      chk("col_sb", dut.r_sb, 32'h88);
      chk("col_inflight", {28'd0, dut.r_inflight}, 1);

      // Spurious writeback and stall saturation
      do_reset();
      wb_valid = 1; wb_rd = 4;
      cyc();
      idle();
      chk("uf_inflight", {28'd0, dut.r_inflight}, 0);
      chk("uf_sb", dut.r_sb, 0);
      op(1, 0, 0, 0);
      iss_ready = 0;
      @(negedge clk);
      chk("sat_iss_valid", {31'd0, iss_valid}, 1);
      chk("sat_ready", {31'd0, dec_ready}, 0);
      for (int i = 0; i < (1 << SW) + 3; i++) cyc();
      chk("sat_stall", {27'd0, stall_cnt}, 31);
      idle();

      // Asynchronous reset while in BR_WAIT
      do_reset();
      op(9, 0, 0, 0);
      cyc();
      op(0, 0, 0, 1);
      cyc();
      idle();
      @(negedge clk);
      chk("pre_busy", {31'd0, busy}, 1);
      chk("pre_sb", dut.r_sb, 32'h200);
      rst = 1;
      #1;
      chk("ar_busy", {31'd0, busy}, 0);
      chk("ar_flush", {31'd0, flush}, 0);
      chk("ar_sb", dut.r_sb, 0);
      chk("ar_inflight", {28'd0, dut.r_inflight}, 0);
      chk("ar_stall", {27'd0, stall_cnt}, 0);
      cyc();
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/trv_issue_ctrl.md
# trv_issue_ctrl

Issue controller between the instruction decoder and the execute stage of the trv core. Accepts one decoded instruction per cycle, holds it back on register read-after-write and write-after-write hazards, on a full in-flight window, or while a branch is unresolved, and signals a fetch flush on taken branches. A 32-entry register scoreboard plus an in-flight counter track outstanding writebacks, and a saturating counter accumulates stall cycles for performance monitoring.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum issued-but-not-written-back instructions (1..15).
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  instruction accepted this cycle.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices; index 0 is the zero register.
- dec_use_rs1, dec_use_rs2  in  1  operand is read from the register file.
- dec_is_br  in  1  conditional or unconditional branch.
- iss_valid  out  1  instruction presented to execute.
- iss_ready  in  1  execute can accept.
- wb_valid  in  1  one instruction retired; pulses once per issued instruction.
- wb_rd  in  5  destination of the retiring instruction; 0 means no register write.
- br_valid  in  1  branch resolved.
- br_taken  in  1  resolved branch taken; qualified by br_valid.
- flush  out  1  discard fetched and decoded instructions.
- busy  out  1  in-flight count is non-zero or state is not RUN.
- stall_cnt  out  STALL_CNT_W  saturating stall-cycle count.

## Operation
- States: RUN, BR_WAIT, FLUSH. Reset state is RUN.
- Hazard:
  - Asserted when (dec_use_rs1 and rs1≠0 and sb[rs1]), or (dec_use_rs2 and rs2≠0 and sb[rs2]), or (rd≠0 and sb[rd]).
  - The rd term is the WAW check.
- Full: inflight == MAX_INFLIGHT.
- iss_valid = RUN and dec_valid and no hazard and not full.
- dec_ready = iss_valid and iss_ready.
- fire = dec_valid and dec_ready.
- Scoreboard update:
  - On fire with dec_rd≠0, set sb[dec_rd].
  - On wb_valid with wb_rd≠0, clear sb[wb_rd].
  - If both hit the same index in one cycle, set wins.
- In-flight counter:
  - +1 on fire, −1 on wb_valid; both in one cycle leaves it unchanged.
  - wb_valid with inflight == 0 is ignored and the counter does not underflow.
- State transitions:
  - RUN → BR_WAIT on fire with dec_is_br.
  - BR_WAIT → FLUSH on br_valid and br_taken.
  - BR_WAIT → RUN on br_valid and not br_taken.
  - FLUSH → RUN unconditionally.
  - br_valid outside BR_WAIT is ignored.
- flush = 1 only in FLUSH. No issue occurs in BR_WAIT or FLUSH, so flush never cancels issued work and the scoreboard is untouched.
- stall_cnt increments in any cycle with dec_valid and not dec_ready, and saturates at all-ones.

## Timing
- Issue latency is zero: iss_valid and dec_ready are combinational from the current state, scoreboard and inputs.
- A scoreboard set becomes visible to hazard checks the cycle after fire.
- A scoreboard clear becomes visible the cycle after wb_valid (see Configuration).
- A branch resolved in cycle N, when taken, drives flush in cycle N+1. Issue resumes no earlier than N+2 (taken) or N+1 (not taken).
- Reset values: state RUN, sb all zero, inflight 0, stall_cnt 0, flush 0, iss_valid 0 (while dec_valid low), busy 0.
- Reset mid-operation: all state clears immediately (asynchronous). The in-flight record is lost; upstream and downstream stages reset together.

## Configuration
- TRV_ISSUE_BYPASS_EN defined:
  - Hazard check uses sb with the same-cycle writeback masked out, i.e. sb & ~(wb_valid and wb_rd≠0 ? onehot(wb_rd) : 0).
  - The full check uses inflight − wb_valid.
  - A dependent instruction can issue in the writeback cycle.
- Undefined: hazard and full checks use the registered values only, costing one extra stall cycle per dependency.

## Test plan
- Back-to-back independent ALU ops (rd 1..4, iss_ready = 1) → four fires in four cycles; busy = 1; inflight reaches 4. A fifth op stalls until the first wb_valid.
- Fire x5 ← …, next op reads rs1 = 5; wb_valid wb_rd = 5 at cycle N → issue at N+1 without TRV_ISSUE_BYPASS_EN, at N with it. stall_cnt equals the stall cycles.
- Branch fires, then br_valid = 1, br_taken = 1 two cycles later → dec_ready = 0 throughout; flush = 1 for exactly one cycle; then RUN. Repeat with br_taken = 0 → no flush.
- Same-cycle fire rd = 7 and wb_valid wb_rd = 7 → sb[7] = 1 afterwards; inflight unchanged.
- wb_valid at inflight = 0 → inflight stays 0. Force stall for 2^STALL_CNT_W + 3 cycles → stall_cnt holds all-ones.
- Assert rst in BR_WAIT with sb nonzero → state RUN, sb 0, inflight 0 and flush 0 immediately, without waiting for a clock edge.
